// File: rtl/crc_stream_enc.sv
// Streaming CRC encoder: forwards each frame word unchanged, then appends one beat carrying the
// frame CRC. Valid/ready on both sides, single-entry output register, one word per clock.
module crc_stream_enc #(
    parameter int unsigned   DW     = 64,
    parameter int unsigned   CW     = 8,
    parameter logic [CW-1:0] POLY   = CW'(8'h07),
    parameter logic [CW-1:0] INIT   = '0,
    parameter logic [CW-1:0] XOROUT = '0
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clr,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    input  logic          s_last,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_last,
    output logic          m_crc_beat
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BODY = 2'd1,
        TAIL = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] crc;

    logic          slot_free;
    logic          acc;
    logic          out_xfer;
    logic [CW-1:0] crc_base;
    logic [CW-1:0] crc_next;

    // Serial MSB-first LFSR over one full word, unrolled into a single combinational step.
    function automatic logic [CW-1:0] crc_fn(input logic [CW-1:0] c, input logic [DW-1:0] d);
        logic [CW-1:0] r;
        logic          fb;
        r = c;
        for (int i = int'(DW) - 1; i >= 0; i--) begin
            fb = r[CW-1] ^ d[i];
            r  = (r << 1) ^ (fb ? POLY : '0);
        end
        return r;
    endfunction

    assign slot_free = !m_valid || m_ready;
    assign s_ready   = reset_n && slot_free && (state != TAIL) && !clr;
    assign acc       = s_valid && s_ready;
    assign out_xfer  = m_valid && m_ready;
    assign crc_base  = (state == IDLE) ? INIT : crc;
    assign crc_next  = crc_fn(crc_base, s_data);

    // Frame FSM, running CRC and output holding register; clr outranks any load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            crc        <= INIT;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_last     <= 1'b0;
            m_crc_beat <= 1'b0;
        end else if (clr) begin
            state      <= IDLE;
            crc        <= INIT;
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
            m_crc_beat <= 1'b0;
        end else begin
            if (out_xfer) begin
                m_valid <= 1'b0;
            end
            case (state)
                IDLE, BODY: begin
                    if (acc) begin
                        m_valid    <= 1'b1;
                        m_data     <= s_data;
                        m_last     <= 1'b0;
                        m_crc_beat <= 1'b0;
                        if (s_last) begin
                            crc   <= crc_next ^ XOROUT;
                            state <= TAIL;
                        end else begin
                            crc   <= crc_next;
                            state <= BODY;
                        end
                    end
                end
                TAIL: begin
                    if (slot_free) begin
                        m_valid    <= 1'b1;
                        m_data     <= DW'(crc) << (DW - CW);
                        m_last     <= 1'b1;
                        m_crc_beat <= 1'b1;
                        crc        <= INIT;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crc_stream_enc.sv
// Bench for crc_stream_enc: a 64-bit and an 8-bit instance checked every cycle against a
// queue-based model whose CRC comes from polynomial long division of the augmented message.
module tb_crc_stream_enc;

    typedef struct packed {
        logic [63:0] data;
        logic        crc;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clr     [2];
    logic        s_valid [2];
    logic        s_last  [2];
    logic        m_ready [2];
    logic [63:0] s_data  [2];
    logic        s_ready [2];
    logic        m_valid [2];
    logic        m_last  [2];
    logic        m_crc_beat [2];
    logic [63:0] m_data64;
    logic [7:0]  m_data8;
    logic [63:0] mdat [2];

    assign mdat[0] = m_data64;
    assign mdat[1] = {56'b0, m_data8};

    crc_stream_enc u_dut64 (
        .clk(clk), .reset_n(reset_n), .clr(clr[0]),
        .s_valid(s_valid[0]), .s_ready(s_ready[0]), .s_data(s_data[0]), .s_last(s_last[0]),
        .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_data(m_data64),
        .m_last(m_last[0]), .m_crc_beat(m_crc_beat[0])
    );

    crc_stream_enc #(.DW(8)) u_dut8 (
        .clk(clk), .reset_n(reset_n), .clr(clr[1]),
        .s_valid(s_valid[1]), .s_ready(s_ready[1]), .s_data(s_data[1][7:0]), .s_last(s_last[1]),
        .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_data(m_data8),
        .m_last(m_last[1]), .m_crc_beat(m_crc_beat[1])
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_err = 0;
    beat_t       exp_q [2][$];
    logic [63:0] frm   [2][$];
    int          crc_cnt [2];
    logic [63:0] last_crc_data [2];
    int          cur_run [2];
    int          max_run [2];
    bit          prev_stall [2];
    logic [63:0] prev_data [2];
    int          rdy_mode [2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // CRC-8 (x^8+x^2+x+1, init 0) as the remainder of message*x^8 divided by the generator.
    function automatic logic [7:0] ref_crc(input logic [63:0] w[$], input int dw);
        logic [8:0] rem = '0;
        foreach (w[j]) begin
            for (int i = dw - 1; i >= 0; i--) begin
                rem = {rem[7:0], w[j][i]};
                if (rem[8]) rem = rem ^ 9'h107;
            end
        end
        for (int i = 0; i < 8; i++) begin
            rem = {rem[7:0], 1'b0};
            if (rem[8]) rem = rem ^ 9'h107;
        end
        return rem[7:0];
    endfunction

    task automatic monitor(input int k);
        string       p;
        beat_t       hd;
        bit          exp_rdy;
        int          n;
        logic [63:0] d;
        logic [7:0]  c;
        p = $sformatf("dut%0d_", k);
        if (!reset_n) begin
            check({p, "rst_m_valid"}, m_valid[k], 0);
            check({p, "rst_s_ready"}, s_ready[k], 0);
            exp_q[k].delete();
            frm[k].delete();
            prev_stall[k] = 0;
            cur_run[k] = 0;
            return;
        end
        n = exp_q[k].size();
        exp_rdy = !clr[k] && (n < 2) && (n == 0 || m_ready[k]);
        check({p, "s_ready"}, s_ready[k], exp_rdy);
        check({p, "m_valid"}, m_valid[k], n != 0);
        if (prev_stall[k] && m_valid[k]) check({p, "stall_stable"}, mdat[k], prev_data[k]);
        if (m_valid[k] && n != 0) begin
            hd = exp_q[k][0];
            check({p, "m_data"}, mdat[k], hd.data);
            check({p, "m_last"}, m_last[k], hd.crc);
            check({p, "m_crc_beat"}, m_crc_beat[k], hd.crc);
            if (m_ready[k]) begin
                if (hd.crc) begin
                    crc_cnt[k]++;
                    last_crc_data[k] = mdat[k];
                end
                void'(exp_q[k].pop_front());
            end
        end
        cur_run[k] = m_valid[k] ? cur_run[k] + 1 : 0;
        if (cur_run[k] > max_run[k]) max_run[k] = cur_run[k];
        prev_stall[k] = m_valid[k] && !m_ready[k] && !clr[k];
        prev_data[k] = mdat[k];
        if (clr[k]) begin
            exp_q[k].delete();
            frm[k].delete();
        end else if (s_valid[k] && s_ready[k]) begin
            d = (k == 1) ? {56'b0, s_data[k][7:0]} : s_data[k];
            exp_q[k].push_back('{data: d, crc: 1'b0});
            frm[k].push_back(d);
            if (s_last[k]) begin
                c = ref_crc(frm[k], (k == 1) ? 8 : 64);
                exp_q[k].push_back('{data: (k == 1) ? {56'b0, c} : {c, 56'b0}, crc: 1'b1});
                frm[k].delete();
            end
        end
    endtask

    always @(negedge clk) begin
        monitor(0);
        monitor(1);
    end

    // Downstream ready patterns: 0 always, 1 random, 2 toggle, 3 held low.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                case (rdy_mode[k])
                    0: m_ready[k] = 1'b1;
                    1: m_ready[k] = ($urandom_range(0, 3) != 0);
                    2: m_ready[k] = ~m_ready[k];
                    default: m_ready[k] = 1'b0;
                endcase
            end
        end
    end

    task automatic send_word(input int k, input logic [63:0] d, input bit last);
        int t = 0;
        s_valid[k] = 1'b1;
        s_data[k] = d;
        s_last[k] = last;
        @(negedge clk);
        while (!s_ready[k] && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!s_ready[k]) check("accept_timeout", s_ready[k], 1);
        @(posedge clk);
        #1;
        s_valid[k] = 1'b0;
        s_last[k] = 1'b0;
    endtask

    task automatic pulse_clr(input int k);
        clr[k] = 1'b1;
        @(posedge clk);
        #1;
        clr[k] = 1'b0;
    endtask

    task automatic drain(input int k);
        int t = 0;
        while (exp_q[k].size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("drain_empty", exp_q[k].size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic send_digits(input int k);
        for (int i = 0; i < 9; i++) send_word(k, 64'h31 + 64'(i), i == 8);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] pq[$];
        int          base;
        int          nw;
        reset_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            clr[k] = 0; s_valid[k] = 0; s_last[k] = 0; s_data[k] = '0; m_ready[k] = 0;
            crc_cnt[k] = 0; max_run[k] = 0; cur_run[k] = 0; rdy_mode[k] = 0;
            prev_stall[k] = 0; last_crc_data[k] = '0;
        end

        // Model pins against hand-known CRC-8 values.
        pq.push_back(64'h1);
        check("pin_crc_one", ref_crc(pq, 64), 8'h07);
        pq.delete();
        for (int i = 0; i < 9; i++) pq.push_back(64'h31 + 64'(i));
        check("pin_crc_digits", ref_crc(pq, 8), 8'hF4);

        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Single-word frame on the 64-bit instance.
        send_word(0, 64'h1, 1);
        drain(0);
        check("t1_crc_beat", last_crc_data[0], 64'h0700000000000000);
        check("t1_crc_count", crc_cnt[0], 1);

        // Two back-to-back single-word zero frames.
        max_run[0] = 0;
        send_word(0, 64'h0, 1);
        send_word(0, 64'h0, 1);
        drain(0);
        check("t6_run", max_run[0], 4);
        check("t6_crc_beat", last_crc_data[0], 64'h0);
        check("t6_crc_count", crc_cnt[0], 3);

        // Reset while the CRC beat is stalled behind a blocked last data beat.
        rdy_mode[0] = 3;
        @(posedge clk);
        #1;
        base = crc_cnt[0];
        send_word(0, 64'h1, 1);
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("t5_m_valid", m_valid[0], 0);
        check("t5_m_last", m_last[0], 0);
        check("t5_m_crc_beat", m_crc_beat[0], 0);
        check("t5_m_data", m_data64, 64'h0);
        check("t5_s_ready", s_ready[0], 0);
        @(posedge clk);
        #2 reset_n = 1'b1;
        #1;
        check("t5_s_ready_release", s_ready[0], 1);
        rdy_mode[0] = 0;
        @(posedge clk);
        #1;
        send_word(0, 64'h1, 1);
        drain(0);
        check("t5_crc_beat", last_crc_data[0], 64'h0700000000000000);
        check("t5_crc_count", crc_cnt[0], base + 1);

        // "123456789" on the 8-bit instance, full rate.
        max_run[1] = 0;
        send_digits(1);
        drain(1);
        check("t2_run", max_run[1], 10);
        check("t2_crc", last_crc_data[1], 64'hF4);

        // Same frame with toggling downstream ready.
        rdy_mode[1] = 2;
        send_digits(1);
        drain(1);
        check("t3_crc", last_crc_data[1], 64'hF4);
        check("t3_crc_count", crc_cnt[1], 2);

        // Abort after five bytes, then resend the whole frame.
        rdy_mode[1] = 0;
        for (int i = 0; i < 5; i++) send_word(1, 64'h31 + 64'(i), 0);
        pulse_clr(1);
        repeat (5) @(posedge clk);
        #1;
        check("t4_no_crc", crc_cnt[1], 2);
        check("t4_idle", m_valid[1], 0);
        send_digits(1);
        drain(1);
        check("t4_crc", last_crc_data[1], 64'hF4);
        check("t4_crc_count", crc_cnt[1], 3);

        // Randomized frames, gaps, backpressure and aborts on both widths.
        for (int k = 0; k < 2; k++) begin
            for (int f = 0; f < 30; f++) begin
                rdy_mode[k] = $urandom_range(0, 2);
                nw = $urandom_range(1, 6);
                for (int w = 0; w < nw; w++) begin
                    if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    send_word(k, {$urandom, $urandom}, w == nw - 1);
                    if ($urandom_range(0, 14) == 0) begin
                        pulse_clr(k);
                        break;
                    end
                end
            end
            rdy_mode[k] = 0;
            drain(k);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
